fetch_unit: RTL

Instruction fetch and PC-sequencing stage for the single-cycle MIPS core. It sits directly upstream of the main controller. It holds the PC, fetches one word per instruction from instruction memory over a req/ack handshake, and presents the decoded instruction fields (opcode, func, rs, rt, rd, imm) to the controller and datapath. At the end of each execute cycle it uses the controller's `pc_src`, `pc_jump` and `jump_sel` outputs to select the next PC.

---
 rtl/fetch_unit.sv | 100 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch and PC sequencing for the single-cycle MIPS core.
// Holds PC and IR, fetches over a req/ack handshake, and selects the next PC.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_FETCH | imem_req high at imem_addr = pc; waits for imem_ack, loads IR
// ST_EXEC  | inst_valid high; holds while stall, else pc <= next_pc
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        pc_src,
    input  logic        pc_jump,
    input  logic        jump_sel,
    input  logic [31:0] rs_data,
    output logic        inst_valid,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  func,
    output logic [15:0] imm,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_err
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] ir;
    logic [31:0] branch_off;
    logic [31:0] next_pc;
    logic        jr_misaligned;

    // Handshake outputs decode straight from the state flop, so they only move on clock edges.
    assign imem_req   = (state == ST_FETCH);
    assign inst_valid = (state == ST_EXEC);
    assign imem_addr  = pc;

    assign opcode = ir[31:26];
    assign rs     = ir[25:21];
    assign rt     = ir[20:16];
    assign rd     = ir[15:11];
    assign func   = ir[5:0];
    assign imm    = ir[15:0];

    assign pc_plus4      = pc + 32'd4;
    assign branch_off    = {{14{ir[15]}}, ir[15:0], 2'b00};
    assign jr_misaligned = pc_jump && !jump_sel && (rs_data[1:0] != 2'b00);

    always_comb begin
        next_pc = pc_plus4;
        if (pc_jump && jump_sel) begin
            next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
        end else if (pc_jump) begin
            next_pc = {rs_data[31:2], 2'b00};
        end else if (pc_src) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_FETCH;
            pc           <= RESET_PC;
            ir           <= 32'h0000_0000;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (!stall) begin
                        pc    <= next_pc;
                        state <= ST_FETCH;
                        if (jr_misaligned) begin
                            misalign_err <= 1'b1;
                        end
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule
